// File: rtl/nboy_input_cond.sv
// Input conditioning for the naughty_boy core: pad routing, per-input
// debounce, and a queued fixed-length coin pulse generator.
module nboy_input_cond #(
    parameter int DEBOUNCE_CYC   = 1100,
    parameter int COIN_PULSE_CYC = 1100000,
    parameter int COIN_GAP_CYC   = 1100000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        cocktail,
    input  logic        pause_cpu,
    output logic        coin,
    output logic [1:0]  starts,
    output logic [4:0]  player1_btns,
    output logic [4:0]  player2_btns,
    output logic        pause_btn,
    output logic [1:0]  credit_q
);

    localparam int NCH  = 14;
    localparam int CW   = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMAX = (COIN_PULSE_CYC > COIN_GAP_CYC) ?
                          COIN_PULSE_CYC : COIN_GAP_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(COIN_PULSE_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(COIN_GAP_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP
    } coin_st_e;

    // hps_io order {U,D,L,R} plus fire -> core order {L,R,D,U,fire}
    function automatic logic [4:0] remap(input logic [4:0] j);
        remap = {j[1], j[0], j[2], j[3], j[4]};
    endfunction

    logic [15:0] j_or;
    logic [4:0]  p1_raw;
    logic [4:0]  p2_raw;
    logic [NCH-1:0] raw;
    logic unused_bits;

    assign j_or   = joystick_0 | joystick_1;
    assign p1_raw = cocktail ? joystick_0[4:0] : j_or[4:0];
    assign p2_raw = cocktail ? joystick_1[4:0] : j_or[4:0];
    assign raw    = {j_or[8], j_or[7], j_or[6], j_or[5],
                     remap(p2_raw), remap(p1_raw)};
    assign unused_bits = ^{joystick_0[15:9], joystick_1[15:9]};

    logic [NCH-1:0] samp_q;
    logic [NCH-1:0] samp_d;
    logic [NCH-1:0] stab_q;
    logic [NCH-1:0] stab_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];

    always_comb begin
        samp_d = raw;
        stab_d = stab_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (samp_q[i] != stab_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    stab_d[i] = samp_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    coin_st_e      state_q;
    coin_st_e      state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [1:0]    credit_d;
    logic          coin_q;
    logic          coin_d;
    logic          coin_prev_q;
    logic          coin_prev_d;
    logic          evt;
    logic          start;
    logic          deq;
    logic          inc;
    logic          idle_run;

    assign coin_prev_d = stab_q[12];
    assign evt         = stab_q[12] & ~coin_prev_q;
    assign idle_run    = (state_q == ST_IDLE) && !pause_cpu;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        credit_d = credit_q;
        start    = 1'b0;
        deq      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!pause_cpu) begin
                    if (credit_q != 2'd0) begin
                        deq   = 1'b1;
                        start = 1'b1;
                    end else if (evt) begin
                        start = 1'b1;
                    end
                end
            end
            ST_PULSE: begin
                if (!pause_cpu) begin
                    if (timer_q == '0) begin
                        state_d = ST_GAP;
                        timer_d = GAP_LAST;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (!pause_cpu) begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - 1'b1;
                    end else if (credit_q != 2'd0) begin
                        deq   = 1'b1;
                        start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            state_d = ST_PULSE;
            timer_d = PULSE_LAST;
        end
        // An event that directly launches a pulse is not queued
        inc = evt && !(idle_run && credit_q == 2'd0);
        if (inc && !deq) begin
            if (credit_q != 2'd3) begin
                credit_d = credit_q + 2'd1;
            end
        end else if (deq && !inc) begin
            credit_d = credit_q - 2'd1;
        end
        coin_d = (state_d == ST_PULSE);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            samp_q      <= '0;
            stab_q      <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            credit_q    <= '0;
            coin_q      <= 1'b0;
            coin_prev_q <= 1'b0;
        end else begin
            samp_q      <= samp_d;
            stab_q      <= stab_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q     <= state_d;
            timer_q     <= timer_d;
            credit_q    <= credit_d;
            coin_q      <= coin_d;
            coin_prev_q <= coin_prev_d;
        end
    end

    assign coin         = coin_q;
    assign player1_btns = stab_q[4:0];
    assign player2_btns = stab_q[9:5];
    assign starts       = stab_q[11:10];
    assign pause_btn    = stab_q[13];

endmodule

// File: tb/tb_nboy_input_cond.sv
// Directed bench for nboy_input_cond with short debounce and coin
// timings; expected values are worked out by hand per step.
module tb_nboy_input_cond;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        cocktail;
    logic        pause_cpu;
    logic        coin;
    logic [1:0]  starts;
    logic [4:0]  player1_btns;
    logic [4:0]  player2_btns;
    logic        pause_btn;
    logic [1:0]  credit_q;

    int nvec = 0;
    int nerr = 0;

    nboy_input_cond #(
        .DEBOUNCE_CYC  (4),
        .COIN_PULSE_CYC(8),
        .COIN_GAP_CYC  (6)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .joystick_0  (joystick_0),
        .joystick_1  (joystick_1),
        .cocktail    (cocktail),
        .pause_cpu   (pause_cpu),
        .coin        (coin),
        .starts      (starts),
        .player1_btns(player1_btns),
        .player2_btns(player2_btns),
        .pause_btn   (pause_btn),
        .credit_q    (credit_q)
    );

    always #5 clk_sys = ~clk_sys;

    // Pulse monitor: high/low time counted only over unpaused cycles
    logic mon_clr = 1'b0;
    int   pulses = 0;
    int   hi_bad = 0;
    int   lo_bad = 0;
    int   cmax = 0;
    int   hi_run = 0;
    int   lo_run = 100;
    logic coin_prev = 1'b0;

    always @(negedge clk_sys) begin
        if (mon_clr) begin
            pulses = 0;
            hi_bad = 0;
            lo_bad = 0;
            cmax = 0;
            hi_run = 0;
            lo_run = 100;
            coin_prev = coin;
        end else begin
            if (coin) begin
                if (!coin_prev) begin
                    pulses++;
                    if (lo_run < 6) lo_bad++;
                    lo_run = 0;
                end
                if (!pause_cpu) hi_run++;
            end else begin
                if (coin_prev) begin
                    if (hi_run != 8) hi_bad++;
                    hi_run = 0;
                end
                if (!pause_cpu) lo_run++;
            end
            coin_prev = coin;
            if (int'(credit_q) > cmax) cmax = int'(credit_q);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk_sys);
        #1 mon_clr = 1'b0;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic coin_press();
        joystick_0[7] = 1'b1;
        tick(6);
        joystick_0[7] = 1'b0;
        tick(6);
    endtask

    initial begin
        reset = 1'b1;
        joystick_0 = '0;
        joystick_1 = '0;
        cocktail = 1'b0;
        pause_cpu = 1'b0;
        tick(3);
        chk("rst_coin", 16'(coin), 16'h0);
        chk("rst_p1", 16'(player1_btns), 16'h0);
        chk("rst_p2", 16'(player2_btns), 16'h0);
        chk("rst_starts", 16'(starts), 16'h0);
        chk("rst_credit", 16'(credit_q), 16'h0);
        reset = 1'b0;
        tick(2);

        // Debounce latency and glitch rejection
        joystick_0[4] = 1'b1;
        tick(4);
        chk("db_early", 16'(player1_btns), 16'h00);
        tick(1);
        chk("db_edge", 16'(player1_btns), 16'h01);
        joystick_0[4] = 1'b0;
        tick(3);
        joystick_0[4] = 1'b1;
        chk("glitch_mid", 16'(player1_btns), 16'h01);
        tick(6);
        chk("glitch_after", 16'(player1_btns), 16'h01);
        joystick_0[4] = 1'b0;
        tick(6);
        chk("db_release", 16'(player1_btns), 16'h00);

        // Routing
        joystick_1[1] = 1'b1;
        tick(6);
        chk("shared_p1", 16'(player1_btns), 16'h10);
        chk("shared_p2", 16'(player2_btns), 16'h10);
        cocktail = 1'b1;
        tick(6);
        chk("cocktail_p1", 16'(player1_btns), 16'h00);
        chk("cocktail_p2", 16'(player2_btns), 16'h10);
        joystick_1[1] = 1'b0;
        cocktail = 1'b0;
        tick(6);

        joystick_0[5] = 1'b1;
        joystick_1[6] = 1'b1;
        joystick_1[8] = 1'b1;
        tick(6);
        chk("starts", 16'(starts), 16'h3);
        chk("pause_btn", 16'(pause_btn), 16'h1);
        joystick_0 = '0;
        joystick_1 = '0;
        tick(6);
        chk("starts_off", 16'(starts), 16'h0);

        // Single coin, held 20 cycles
        clr_mon();
        joystick_0[7] = 1'b1;
        tick(5);
        chk("coin_pre", 16'(coin), 16'h0);
        tick(1);
        chk("coin_rise", 16'(coin), 16'h1);
        tick(7);
        chk("coin_last_hi", 16'(coin), 16'h1);
        tick(1);
        chk("coin_fall", 16'(coin), 16'h0);
        tick(6);
        joystick_0[7] = 1'b0;
        tick(30);
        chk("single_pulses", 16'(pulses), 16'd1);
        chk("single_hi", 16'(hi_bad), 16'd0);
        chk("single_credit", 16'(cmax), 16'd0);

        // Queue saturation: presses made while the pulse is frozen
        clr_mon();
        joystick_0[7] = 1'b1;
        tick(6);
        chk("q_first", 16'(coin), 16'h1);
        pause_cpu = 1'b1;
        joystick_0[7] = 1'b0;
        tick(6);
        for (int i = 0; i < 4; i++) coin_press();
        chk("q_sat", 16'(credit_q), 16'd3);
        chk("q_hold", 16'(coin), 16'h1);
        pause_cpu = 1'b0;
        tick(100);
        chk("q_pulses", 16'(pulses), 16'd4);
        chk("q_hi", 16'(hi_bad), 16'd0);
        chk("q_lo", 16'(lo_bad), 16'd0);
        chk("q_cmax", 16'(cmax), 16'd3);
        chk("q_drain", 16'(credit_q), 16'd0);

        // Pause at timer=4 mid-pulse
        clr_mon();
        joystick_0[7] = 1'b1;
        tick(6);
        joystick_0[7] = 1'b0;
        tick(3);
        pause_cpu = 1'b1;
        tick(20);
        chk("pause_hold", 16'(coin), 16'h1);
        pause_cpu = 1'b0;
        tick(4);
        chk("pause_tail", 16'(coin), 16'h1);
        tick(1);
        chk("pause_fall", 16'(coin), 16'h0);
        tick(20);
        chk("pause_pulses", 16'(pulses), 16'd1);
        chk("pause_hi", 16'(hi_bad), 16'd0);

        // Reset mid-pulse with two queued coins
        joystick_0[7] = 1'b1;
        tick(6);
        chk("r_pulse", 16'(coin), 16'h1);
        pause_cpu = 1'b1;
        joystick_0[7] = 1'b0;
        joystick_0[4] = 1'b1;
        joystick_1[5] = 1'b1;
        tick(6);
        coin_press();
        coin_press();
        chk("r_credit", 16'(credit_q), 16'd2);
        chk("r_p1", 16'(player1_btns), 16'h01);
        chk("r_starts", 16'(starts), 16'h1);
        reset = 1'b1;
        joystick_0 = '0;
        joystick_1 = '0;
        pause_cpu = 1'b0;
        tick(1);
        chk("r_coin", 16'(coin), 16'h0);
        chk("r_credit0", 16'(credit_q), 16'd0);
        chk("r_p1_0", 16'(player1_btns), 16'h0);
        chk("r_p2_0", 16'(player2_btns), 16'h0);
        chk("r_starts0", 16'(starts), 16'h0);
        reset = 1'b0;
        clr_mon();
        tick(40);
        chk("r_nopulse", 16'(pulses), 16'd0);
        chk("r_coin_lo", 16'(coin), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
